col_drain_arbiter: RTL and testbench
====================================

// Module: col_drain_arbiter
// PURPOSE
//  Drains the per-column result buffers of the systolic array onto one output stream.
//  Round-robin arbitration across COLS columns; pulses a one-hot read strobe to the granted column.
//  Tags each beat with column/row index and flags the final beat of a tile.
//  Sits between the column output buffers and the top-level result port.
// PARAMETERS
//  COLS      8   number of PE columns / column buffers
//  ROWS      8   results per column per tile
//  OUTWIDTH  32  result width
//  COLW      $clog2(COLS)      column index width
//  ROWW      $clog2(ROWS+1)    per-column counter width
// PORTS
//  clk        in   1         clock
//  rstn       in   1         reset, synchronous, active-low
//  start      in   1         begin draining one tile (ROWS*COLS results)
//  col_data   in   OUTWIDTH  [0:COLS-1] head result of each column buffer
//  col_valid  in   1         [0:COLS-1] column buffer holds an unread result
//  col_read   out  1         [0:COLS-1] one-cycle read strobe, at most one bit set
//  out_data   out  OUTWIDTH  registered result
//  out_col    out  COLW      source column of out_data
//  out_row    out  ROWW      row index (per-column beat count) of out_data
//  out_valid  out  1         out_* holds a beat
//  out_ready  in   1         downstream accepts beat when out_valid & out_ready
//  out_last   out  1         beat is the ROWS*COLS-th of the tile
//  busy       out  1         state != IDLE
//  done       out  1         one-cycle pulse at end of tile
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer 0, all per-column counts 0, total count 0.
//  FSM: IDLE -start-> DRAIN -last beat accepted-> DONE -(1 cycle)-> IDLE.
//   start ignored outside IDLE; in IDLE col_read is all-zero, out_valid 0.
//   Entering DRAIN clears per-column counts and total count; rr pointer holds its value.
//  Eligible column c: col_valid[c]=1 and cnt[c] < ROWS.
//  Load condition (DRAIN): (!out_valid | out_ready) and total issued < ROWS*COLS and any eligible.
//  Grant: first eligible column searching ptr, ptr+1, ... wrapping mod COLS.
//  Cycle N (load true): col_read[g]=1 (combinational), col_data[g] sampled.
//  Cycle N+1: out_data=col_data[g], out_col=g, out_row=cnt[g] (pre-increment), out_valid=1;
//   cnt[g]++, total++, ptr=(g+1) mod COLS. Latency grant->out_valid = 1 cycle.
//  Throughput 1 beat/cycle while out_ready=1 and eligible columns exist.
//  Stall: out_valid & !out_ready -> out_* held stable, col_read all-zero, no counter change.
//  Accept without reload: out_valid cleared next cycle.
//  out_last=1 on the beat where total reaches ROWS*COLS; no further col_read that tile.
//  Accept of out_last beat -> state DONE; done=1 for that single cycle, out_valid=0.
//  Column with cnt==ROWS never granted again this tile, even with col_valid=1.
//  No eligible column: no strobe, out_valid drops after current beat accepted; wait.
//  rstn low mid-tile: immediate return to reset state next edge; partial tile discarded.
//  Column buffers update col_valid one cycle after col_read; block must not rely on same-cycle update
//   (a granted column is excluded by cnt/stall rules until out reg frees, so no double read).
// TESTING
//  1 Reset: hold rstn=0 3 cycles -> col_read=0, out_valid=0, busy=0, done=0, out_data=0.
//  2 All col_valid=1, out_ready=1, start -> 64 beats on consecutive cycles, out_col 0..7
//    repeating, out_row 0 x8 then 1 x8 ..., out_last only on beat 64, done 1 cycle after.
//  3 As 2 with out_ready toggling 1/0 -> out_data/out_col stable while stalled, no col_read
//    during stall, 64 beats total, order identical to test 2.
//  4 Only col_valid[3],[5]=1 -> grants alternate 3,5,3,5...; after 8 each no more strobes,
//    busy stays 1 until others fill; then remaining columns drained, done pulses.
//  5 col_valid[2] forced 1 throughout -> exactly 8 col_read[2] strobes per tile; start
//    while busy -> ignored, no counter reset.
//  6 rstn=0 after beat 20 -> next cycle outputs all 0, IDLE; new start drains full 64 beats.

Source files
------------

// File: rtl/col_drain_if.sv
// Column-drain bus: column buffer heads/strobes in, tagged result stream out.
// Ports (master = arbiter side):
//   in : start, col_data[COLS], col_valid[COLS], out_ready
//   out: col_read[COLS], out_data, out_col, out_row, out_valid, out_last, busy, done
interface col_drain_if #(
    parameter int unsigned COLS     = 8,
    parameter int unsigned ROWS     = 8,
    parameter int unsigned OUTWIDTH = 32
);
    localparam int unsigned COLW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned ROWW = $clog2(ROWS + 1);

    logic                               start;
    logic [COLS-1:0][OUTWIDTH-1:0]      col_data;
    logic [COLS-1:0]                    col_valid;
    logic [COLS-1:0]                    col_read;
    logic [OUTWIDTH-1:0]                out_data;
    logic [COLW-1:0]                    out_col;
    logic [ROWW-1:0]                    out_row;
    logic                               out_valid;
    logic                               out_ready;
    logic                               out_last;
    logic                               busy;
    logic                               done;

    modport master (
        input  start, col_data, col_valid, out_ready,
        output col_read, out_data, out_col, out_row, out_valid, out_last, busy, done
    );

    modport slave (
        output start, col_data, col_valid, out_ready,
        input  col_read, out_data, out_col, out_row, out_valid, out_last, busy, done
    );
endinterface

// File: rtl/col_drain_arbiter.sv
// Round-robin drain of COLS column result buffers onto one registered output stream.
// Each tile is ROWS results per column; beats are tagged with source column and
// per-column row index, the final beat carries out_last and done pulses afterwards.
// Ports: clk, rstn (synchronous, active-low), bus (col_drain_if.master).
module col_drain_arbiter #(
    parameter int unsigned COLS     = 8,
    parameter int unsigned ROWS     = 8,
    parameter int unsigned OUTWIDTH = 32
) (
    input  logic        clk,
    input  logic        rstn,
    col_drain_if.master bus
);
    localparam int unsigned COLW  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned ROWW  = $clog2(ROWS + 1);
    localparam int unsigned TOTAL = ROWS * COLS;
    localparam int unsigned TOTW  = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    state_t              state;
    logic [COLW-1:0]     ptr;
    logic [ROWW-1:0]     cnt [COLS];
    logic [TOTW-1:0]     total;

    logic [OUTWIDTH-1:0] out_data_q;
    logic [COLW-1:0]     out_col_q;
    logic [ROWW-1:0]     out_row_q;
    logic                out_valid_q;
    logic                out_last_q;
    logic                busy_q;
    logic                done_q;

    logic [COLS-1:0]     eligible_c;
    logic                any_c;
    logic [COLW-1:0]     grant_c;
    logic [COLW-1:0]     idx_c;
    logic                load_c;

    // A column may be read while it has data and has not yet supplied ROWS results.
    always_comb begin
        eligible_c = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            eligible_c[c] = bus.col_valid[c] && (cnt[c] < ROWW'(ROWS));
        end
    end

    // First eligible column at or after the round-robin pointer.
    always_comb begin
        any_c   = 1'b0;
        grant_c = '0;
        idx_c   = '0;
        for (int unsigned k = 0; k < COLS; k++) begin
            idx_c = COLW'((32'(ptr) + k) % COLS);
            if (!any_c && eligible_c[idx_c]) begin
                any_c   = 1'b1;
                grant_c = idx_c;
            end
        end
    end

    // Reload only when the output register is free or being emptied this cycle.
    assign load_c = (state == DRAIN) && (!out_valid_q || bus.out_ready)
                    && (total < TOTW'(TOTAL)) && any_c;

    // Read strobe is combinational so the column head is sampled in the same cycle.
    always_comb begin
        bus.col_read = '0;
        if (load_c) begin
            bus.col_read[grant_c] = 1'b1;
        end
    end

    // Control FSM, counters and output register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            ptr         <= '0;
            total       <= '0;
            out_data_q  <= '0;
            out_col_q   <= '0;
            out_row_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int unsigned c = 0; c < COLS; c++) begin
                cnt[c] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state  <= DRAIN;
                        busy_q <= 1'b1;
                        total  <= '0;
                        for (int unsigned c = 0; c < COLS; c++) begin
                            cnt[c] <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (load_c) begin
                        out_data_q   <= bus.col_data[grant_c];
                        out_col_q    <= grant_c;
                        out_row_q    <= cnt[grant_c];
                        out_valid_q  <= 1'b1;
                        out_last_q   <= (total == TOTW'(TOTAL - 1));
                        cnt[grant_c] <= cnt[grant_c] + ROWW'(1);
                        total        <= total + TOTW'(1);
                        ptr          <= (grant_c == COLW'(COLS - 1)) ? '0 : grant_c + COLW'(1);
                    end else if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (out_last_q) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_col   = out_col_q;
    assign bus.out_row   = out_row_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_col_drain_arbiter.sv
// Bench for col_drain_arbiter: directed tiles checked every cycle against a
// behavioural model, plus literal expectations on the accepted beat sequence.
module tb_col_drain_arbiter;
    localparam int unsigned COLS  = 8;
    localparam int unsigned ROWS  = 8;
    localparam int unsigned OW    = 32;
    localparam int          TOTAL = ROWS * COLS;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    col_drain_if #(.COLS(COLS), .ROWS(ROWS), .OUTWIDTH(OW)) bus ();

    col_drain_arbiter #(.COLS(COLS), .ROWS(ROWS), .OUTWIDTH(OW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int tile  = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_phase: 0 idle, 1 draining, 2 done cycle
    int            m_phase;
    int            m_cnt [COLS];
    int            m_total;
    int            m_ptr;
    bit            m_ov;
    bit            m_last;
    logic [OW-1:0] m_data;
    int            m_col;
    int            m_row;
    int            m_g;

    function automatic int grant_of(input logic [COLS-1:0] v);
        if (m_phase != 1) return -1;
        if (m_ov && !bus.out_ready) return -1;
        if (m_total >= TOTAL) return -1;
        for (int k = 0; k < COLS; k++) begin
            int c;
            c = (m_ptr + k) % COLS;
            if (v[c] && m_cnt[c] < ROWS) return c;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (!rstn) begin
            m_phase = 0; m_total = 0; m_ptr = 0; m_ov = 0; m_last = 0;
            m_data = '0; m_col = 0; m_row = 0;
            foreach (m_cnt[c]) m_cnt[c] = 0;
        end else if (m_phase == 0) begin
            if (bus.start) begin
                m_phase = 1; m_total = 0;
                foreach (m_cnt[c]) m_cnt[c] = 0;
            end
        end else if (m_phase == 1) begin
            m_g = grant_of(bus.col_valid);
            if (m_g >= 0) begin
                m_data = bus.col_data[m_g];
                m_col  = m_g;
                m_row  = m_cnt[m_g];
                m_cnt[m_g] += 1;
                m_total += 1;
                m_ov   = 1;
                m_last = (m_total == TOTAL);
                m_ptr  = (m_g + 1) % COLS;
            end else if (m_ov && bus.out_ready) begin
                if (m_last) m_phase = 2;
                m_ov = 0; m_last = 0;
            end
        end else begin
            m_phase = 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            int g;
            logic [COLS-1:0] exp_rd;
            g = grant_of(bus.col_valid);
            exp_rd = (g >= 0) ? (COLS'(1) << g) : '0;
            check("col_read", 64'(bus.col_read), 64'(exp_rd));
            check("out_valid", 64'(bus.out_valid), 64'(m_ov));
            check("out_last", 64'(bus.out_last), 64'(m_last));
            check("busy", 64'(bus.busy), 64'(m_phase != 0));
            check("done", 64'(bus.done), 64'(m_phase == 2));
            if (m_ov) begin
                check("out_data", 64'(bus.out_data), 64'(m_data));
                check("out_col", 64'(bus.out_col), 64'(m_col));
                check("out_row", 64'(bus.out_row), 64'(m_row));
            end
        end
    end

    // ---------------- accepted-beat log and strobe counter ----------------
    typedef struct {
        int col;
        int row;
        bit last;
    } beat_t;
    beat_t acc_q[$];
    int    rd2 = 0;

    always @(negedge clk) begin
        if (rstn && bus.out_valid && bus.out_ready)
            acc_q.push_back('{col: int'(bus.out_col), row: int'(bus.out_row), last: bus.out_last});
        if (bus.col_read[2]) rd2++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < COLS; c++)
            bus.col_data[c] = {8'(tile), 8'(c), 16'(cyc)};
    endtask

    task automatic pulse_start();
        tile++;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            step();
            if (bus.done) seen = 1'b1;
        end
        check(nm, 64'(seen), 64'd1);
        step();
    endtask

    int ref_col [TOTAL];
    int ref_row [TOTAL];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn          = 1'b0;
        bus.start     = 1'b0;
        bus.col_valid = '0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < COLS; c++) bus.col_data[c] = '0;

        // 1: reset
        repeat (3) step();
        chk_en = 1'b1;
        check("rst_col_read", 64'(bus.col_read), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        rstn = 1'b1;
        step();

        // 2: full-rate drain
        bus.col_valid = '1;
        bus.out_ready = 1'b1;
        acc_q.delete();
        pulse_start();
        wait_done("t2_done", 200);
        check("t2_beats", 64'(acc_q.size()), 64'd64);
        if (acc_q.size() == TOTAL) begin
            check("t2_b0_col", 64'(acc_q[0].col), 64'd0);
            check("t2_b9_col", 64'(acc_q[9].col), 64'd1);
            check("t2_b9_row", 64'(acc_q[9].row), 64'd1);
            check("t2_b62_last", 64'(acc_q[62].last), 64'd0);
            check("t2_b63_last", 64'(acc_q[63].last), 64'd1);
            check("t2_b63_col", 64'(acc_q[63].col), 64'd7);
            check("t2_b63_row", 64'(acc_q[63].row), 64'd7);
            for (int i = 0; i < TOTAL; i++) begin
                ref_col[i] = acc_q[i].col;
                ref_row[i] = acc_q[i].row;
            end
        end

        // 3: out_ready toggling, same order expected
        acc_q.delete();
        pulse_start();
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 400 && !seen; i++) begin
                bus.out_ready = ~bus.out_ready;
                step();
                if (bus.done) seen = 1'b1;
            end
            check("t3_done", 64'(seen), 64'd1);
        end
        bus.out_ready = 1'b1;
        step();
        check("t3_beats", 64'(acc_q.size()), 64'd64);
        if (acc_q.size() == TOTAL) begin
            for (int i = 0; i < TOTAL; i += 7) begin
                check("t3_order_col", 64'(acc_q[i].col), 64'(ref_col[i]));
                check("t3_order_row", 64'(acc_q[i].row), 64'(ref_row[i]));
            end
        end

        // 4: only columns 3 and 5 have data, then the rest fill
        bus.col_valid = 8'b0010_1000;
        acc_q.delete();
        pulse_start();
        repeat (40) step();
        check("t4_partial_beats", 64'(acc_q.size()), 64'd16);
        check("t4_busy_wait", 64'(bus.busy), 64'd1);
        if (acc_q.size() >= 16) begin
            check("t4_b0_col", 64'(acc_q[0].col), 64'd3);
            check("t4_b1_col", 64'(acc_q[1].col), 64'd5);
            check("t4_b14_col", 64'(acc_q[14].col), 64'd3);
            check("t4_b15_col", 64'(acc_q[15].col), 64'd5);
        end
        bus.col_valid = '1;
        wait_done("t4_done", 200);
        check("t4_beats", 64'(acc_q.size()), 64'd64);
        if (acc_q.size() > 16)
            check("t4_b16_col", 64'(acc_q[16].col), 64'd6);

        // 5: column 2 always valid, random others, restart attempt while busy
        acc_q.delete();
        rd2 = 0;
        pulse_start();
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 3000 && !seen; i++) begin
                bus.col_valid = COLS'($urandom) | 8'h04;
                bus.out_ready = 1'($urandom_range(0, 3) != 0);
                bus.start     = (i == 10);
                step();
                if (bus.done) seen = 1'b1;
            end
            check("t5_done", 64'(seen), 64'd1);
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        bus.col_valid = '1;
        step();
        check("t5_col2_strobes", 64'(rd2), 64'd8);
        check("t5_beats", 64'(acc_q.size()), 64'd64);

        // 6: reset mid-tile, then a fresh full tile
        acc_q.delete();
        pulse_start();
        for (int i = 0; i < 100 && acc_q.size() < 20; i++) step();
        check("t6_reached20", 64'(acc_q.size() >= 20), 64'd1);
        rstn = 1'b0;
        step();
        check("t6_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("t6_rst_busy", 64'(bus.busy), 64'd0);
        check("t6_rst_done", 64'(bus.done), 64'd0);
        check("t6_rst_col_read", 64'(bus.col_read), 64'd0);
        check("t6_rst_out_data", 64'(bus.out_data), 64'd0);
        check("t6_rst_out_last", 64'(bus.out_last), 64'd0);
        rstn = 1'b1;
        step();
        acc_q.delete();
        pulse_start();
        wait_done("t6_done", 200);
        check("t6_beats", 64'(acc_q.size()), 64'd64);
        if (acc_q.size() > 0)
            check("t6_b0_col", 64'(acc_q[0].col), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
